// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
//   Shared definitions for the UART receive path: byte width, the stored
//   entry width and the entry layout, with the framing-error flag in the MSB.
//   The UART receiver and transmitter blocks use the same definitions.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_ENTRY_W = UART_DATA_W + 1;

  // One stored FIFO entry: error flag in the MSB, data byte below it.
  typedef struct packed {
    logic                   error;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Handshake bundle around the receive FIFO.
//   Receiver side : rx_req / rx_ready / rx_data / rx_error
//                   (a byte transfers when rx_req & rx_ready)
//   Consumer side : rd_valid / rd_ready / rd_data / rd_error
//                   (first-word-fall-through, pop when rd_valid & rd_ready)
//   slave  modport : the FIFO itself.
//   master modport : the environment driving the receiver and consumer sides.
interface uart_rx_fifo_if;
  import uart_rx_fifo_pkg::*;

  logic                   rx_req;
  logic                   rx_ready;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_error;

  logic                   rd_valid;
  logic                   rd_ready;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_error;

  modport slave (
    input  rx_req, rx_data, rx_error, rd_ready,
    output rx_ready, rd_valid, rd_data, rd_error
  );

  modport master (
    output rx_req, rx_data, rx_error, rd_ready,
    input  rx_ready, rd_valid, rd_data, rd_error
  );

endinterface : uart_rx_fifo_if

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p
//   DEPTH x WIDTH register array: one synchronous write port, one
//   asynchronous (combinational) read port. Suitable for FWFT FIFOs.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fifo_mem_2p #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage carries no reset; validity is tracked by the owner's
  // pointers, and leaving the array unreset lets it map to plain flops or RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem_2p

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer downstream of the UART receiver. Each received byte and
//   its framing-error flag go into a DEPTH-entry FWFT FIFO. The receiver is
//   never back-pressured; bytes arriving while full are dropped and counted.
//   clk         : system clock, posedge
//   reset_      : asynchronous active-low reset
//   bus         : receiver and consumer handshakes (slave modport)
//   level       : occupancy 0..DEPTH
//   overrun     : sticky, at least one byte dropped since last clear
//   drop_cnt    : saturating count of dropped bytes
//   clr_overrun : one-cycle pulse clearing overrun and drop_cnt
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_,
  uart_rx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   clr_overrun
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Pointers differ only in the wrap bit exactly when the FIFO is full.
  localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rx_ready_q;

  logic      empty;
  logic      full;
  logic      push_evt;
  logic      pop;
  logic      push_ok;
  logic      drop;
  rx_entry_t wr_entry;
  rx_entry_t rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);

  assign push_evt = bus.rx_req & rx_ready_q;
  assign pop      = bus.rd_valid & bus.rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_evt & (~full | pop);
  assign drop     = push_evt & full & ~pop;

  assign wr_entry = '{error: bus.rx_error, data: bus.rx_data};

  fifo_mem_2p #(
    .DEPTH (DEPTH),
    .WIDTH (UART_ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  assign bus.rx_ready = rx_ready_q;
  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = rd_entry.data;
  assign bus.rd_error = rd_entry.error;
  assign level        = wr_ptr - rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_ready_q <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clr_overrun)     drop_cnt <= CNT_W'(1);
      else if (~&drop_cnt) drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (clr_overrun) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo (DEPTH=16, CNT_W=4). A reference
//   model keeps the FIFO contents in a queue and the drop statistics as
//   integers; a monitor on the falling edge compares every visible output
//   against it and checks the head entry whenever the DUT is popped.
module tb_uart_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_ = 1'b1;
  logic [4:0]       level;
  logic             overrun;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr_overrun = 1'b0;

  uart_rx_fifo_if bus_if ();

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .bus         (bus_if.slave),
    .level       (level),
    .overrun     (overrun),
    .drop_cnt    (drop_cnt),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] model_q[$];     // {error, data}, oldest first
  bit         m_ready   = 0;
  bit         m_overrun = 0;
  int         m_drop    = 0;
  bit         mon_en    = 0;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      model_q.delete();
      m_ready   = 0;
      m_overrun = 0;
      m_drop    = 0;
    end else begin
      bit push_evt, do_pop, was_full;
      push_evt = bus_if.rx_req && m_ready;
      do_pop   = (model_q.size() > 0) && bus_if.rd_ready;
      was_full = (model_q.size() == DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (push_evt && (!was_full || do_pop)) begin
        model_q.push_back({bus_if.rx_error, bus_if.rx_data});
      end else if (push_evt) begin
        m_overrun = 1;
        m_drop    = clr_overrun ? 1 : ((m_drop >= CNT_MAX) ? CNT_MAX : m_drop + 1);
      end else if (clr_overrun) begin
        m_overrun = 0;
        m_drop    = 0;
      end
      m_ready = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_level",    32'(level),           32'(model_q.size()));
      check("mon_rd_valid", 32'(bus_if.rd_valid), 32'(model_q.size() != 0));
      check("mon_rx_ready", 32'(bus_if.rx_ready), 32'(m_ready));
      check("mon_overrun",  32'(overrun),         32'(m_overrun));
      check("mon_drop_cnt", 32'(drop_cnt),        32'(m_drop));
      if (bus_if.rd_valid && bus_if.rd_ready && model_q.size() > 0) begin
        check("mon_pop_entry", 32'({bus_if.rd_error, bus_if.rd_data}), 32'(model_q[0]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Return 2 time units after the next rising edge; inputs change there.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e);
    bus_if.rx_req   = 1'b1;
    bus_if.rx_data  = d;
    bus_if.rx_error = e;
    tick();
    bus_if.rx_req = 1'b0;
  endtask

  task automatic drain();
    bus_if.rd_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH && bus_if.rd_valid; i++) tick();
    bus_if.rd_ready = 1'b0;
  endtask

  task automatic clear_overrun();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last;
    bus_if.rx_req   = 1'b0;
    bus_if.rx_data  = '0;
    bus_if.rx_error = 1'b0;
    bus_if.rd_ready = 1'b0;

    #1 reset_ = 1'b0;
    #21 reset_ = 1'b1;
    #1;
    check("reset_rx_ready", 32'(bus_if.rx_ready), 32'h0);
    check("reset_rd_valid", 32'(bus_if.rd_valid), 32'h0);
    check("reset_level",    32'(level),           32'h0);
    mon_en = 1;
    tick();
    check("rx_ready_after_release", 32'(bus_if.rx_ready), 32'h1);

    // Single byte
    push_byte(8'h41, 1'b0);
    check("single_rd_valid", 32'(bus_if.rd_valid), 32'h1);
    check("single_rd_data",  32'(bus_if.rd_data),  32'h41);
    check("single_level",    32'(level),           32'h1);
    bus_if.rd_ready = 1'b1;
    tick();
    bus_if.rd_ready = 1'b0;
    check("single_pop_valid", 32'(bus_if.rd_valid), 32'h0);
    check("single_pop_level", 32'(level),           32'h0);

    // Error propagation
    push_byte(8'h55, 1'b1);
    push_byte(8'h56, 1'b0);
    check("err_head0", 32'({bus_if.rd_error, bus_if.rd_data}), 32'h155);
    bus_if.rd_ready = 1'b1;
    tick();
    check("err_head1", 32'({bus_if.rd_error, bus_if.rd_data}), 32'h056);
    tick();
    bus_if.rd_ready = 1'b0;

    // Overflow: 17 bytes into 16 slots
    for (int i = 0; i <= 16; i++) push_byte(8'(i), 1'b0);
    check("ovf_level",    32'(level),    32'd16);
    check("ovf_overrun",  32'(overrun),  32'h1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
    bus_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_data", 32'(bus_if.rd_data), 32'(i));
      tick();
    end
    bus_if.rd_ready = 1'b0;
    check("ovf_drained_level", 32'(level), 32'h0);
    clear_overrun();
    check("clr_overrun",  32'(overrun),  32'h0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'h0);

    // Full push + pop in one cycle
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b0);
    bus_if.rx_req   = 1'b1;
    bus_if.rx_data  = 8'hAA;
    bus_if.rd_ready = 1'b1;
    tick();
    bus_if.rx_req   = 1'b0;
    bus_if.rd_ready = 1'b0;
    check("fullpp_level",   32'(level),   32'd16);
    check("fullpp_overrun", 32'(overrun), 32'h0);
    bus_if.rd_ready = 1'b1;
    last = 8'h00;
    for (int i = 0; i < 2 * DEPTH && bus_if.rd_valid; i++) begin
      last = bus_if.rd_data;
      tick();
    end
    bus_if.rd_ready = 1'b0;
    check("fullpp_last_byte", 32'(last), 32'hAA);

    // Random stream across pointer wrap
    for (int i = 0; i < 300; i++) begin
      bus_if.rx_req   = 1'($urandom_range(0, 1));
      bus_if.rx_data  = 8'($urandom);
      bus_if.rx_error = 1'($urandom_range(0, 1));
      bus_if.rd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus_if.rx_req = 1'b0;
    drain();
    clear_overrun();

    // Saturation: 16 fills then 20 drops
    for (int i = 0; i < 36; i++) push_byte(8'($urandom), 1'($urandom_range(0, 1)));
    check("sat_drop_cnt", 32'(drop_cnt), 32'd15);
    check("sat_overrun",  32'(overrun),  32'h1);
    bus_if.rx_req = 1'b1;
    clr_overrun   = 1'b1;
    tick();
    bus_if.rx_req = 1'b0;
    clr_overrun   = 1'b0;
    check("drop_and_clr_cnt",     32'(drop_cnt), 32'h1);
    check("drop_and_clr_overrun", 32'(overrun),  32'h1);
    clear_overrun();
    drain();

    // Reset mid-stream at level 5
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), 1'b0);
    check("pre_reset_level", 32'(level), 32'd5);
    #1 reset_ = 1'b0;
    #1;
    check("midrst_level",    32'(level),           32'h0);
    check("midrst_rd_valid", 32'(bus_if.rd_valid), 32'h0);
    check("midrst_rx_ready", 32'(bus_if.rx_ready), 32'h0);
    #4 reset_ = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_rx_ready", 32'(bus_if.rx_ready), 32'h1);
    #1;
    push_byte(8'h77, 1'b1);
    check("post_rst_rd_valid", 32'(bus_if.rd_valid), 32'h1);
    check("post_rst_entry",    32'({bus_if.rd_error, bus_if.rd_data}), 32'h177);
    drain();
    tick();

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer sitting directly downstream of the UART receiver. It consumes the receiver's rx_req/rx_ready/rx_data/rx_error handshake and stores each byte with its framing-error flag in a DEPTH-entry FIFO. It presents bytes to the consumer (CPU bus bridge or command parser) through a first-word-fall-through valid/ready port. Bytes that arrive while the FIFO is full are dropped and counted, so overruns are visible instead of silent.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  single system clock, all logic on posedge
reset_  input  1  asynchronous active-low reset
rx_req  input  1  receiver has a byte; held until rx_ready is seen
rx_ready  output  1  acknowledge to receiver; transfer when rx_req & rx_ready
rx_data  input  8  received byte
rx_error  input  1  stop-bit error flag for rx_data
rd_valid  output  1  FIFO non-empty; rd_data/rd_error valid
rd_ready  input  1  consumer pops when rd_valid & rd_ready
rd_data  output  8  head byte
rd_error  output  1  head byte's error flag
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: at least one byte dropped since last clear
drop_cnt  output  CNT_W  saturating count of dropped bytes
clr_overrun  input  1  one-cycle pulse: clear overrun and drop_cnt

Behaviour:
- Reset (async assert, sync release): pointers 0, level 0, rd_valid 0, rx_ready 0, overrun 0, drop_cnt 0. rd_data/rd_error are don't-care while rd_valid=0.
- rx_ready is a register: 0 in reset, 1 from the first clock after reset release, 1 forever after. The FIFO never back-pressures the receiver, because the receiver overwrites unacknowledged data anyway.
- push_evt = rx_req & rx_ready. pop = rd_valid & rd_ready.
- Push accepted iff push_evt & (!full | pop). Simultaneous push and pop when full: both occur, and level stays DEPTH.
- Push rejected (push_evt & full & !pop): overrun <= 1 and drop_cnt <= drop_cnt+1, saturating at all-ones. The byte is discarded.
- Pop on empty is impossible, because rd_valid=0.
- Simultaneous push and pop when empty: no pop (rd_valid=0). The push is accepted and level becomes 1.
- Latency: a byte accepted at edge N gives rd_valid=1 with that byte on rd_data after edge N. rd_data is combinational from storage at the read pointer (FWFT). Pop at edge N exposes the next entry after edge N.
- Pointers are $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty. full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}. Pointers wrap naturally modulo 2*DEPTH.
- level = wr_ptr - rd_ptr, modulo width. It is registered via the pointers, not a separate counter.
- clr_overrun in the same cycle as a drop: the drop wins, giving overrun=1 and drop_cnt=1.
- Storage is not reset; only pointers and flags are.
- Reset asserted mid-operation: FIFO empties immediately, rx_ready drops to 0, and all pending bytes are lost.

Decomposition:
- Shared header uart_defs.vh: UART_DATA_W=8 and the stored entry width UART_DATA_W+1 (error flag in MSB). The header is shared with uart_rx and uart_tx.
- One sub-module: fifo_mem_2p, a DEPTH x 9 register array with a synchronous write port and an asynchronous read port. It is reused later by the TX FIFO.
- Pointer, flag and counter logic stays in uart_rx_fifo.

Test Plan:
- Single byte: after reset, pulse rx_req with 0x41 and rx_error=0. Required: rx_ready=1, rd_valid rises the next cycle, rd_data=0x41, level=1. Pop, and required: rd_valid=0, level=0.
- Error propagation: push 0x55 with rx_error=1, then 0x56 with rx_error=0. Required: pops return (0x55,1) then (0x56,0) in order.
- Overflow: rd_ready=0, push 0x00..0x10 (17 bytes). Required: level=16, overrun=1, drop_cnt=1. Draining returns exactly 0x00..0x0F. Then pulse clr_overrun, and required: overrun=0, drop_cnt=0.
- Full push+pop: at level=16, push 0xAA in the same cycle as a pop. Required: level stays 16, overrun stays 0, and 0xAA is the last byte drained.
- Wrap and saturation: with CNT_W=4, stream 100 bytes with random pop gaps. Required: data order is preserved across pointer wrap. Force 20 drops while full, and required: drop_cnt=15 (saturated). Drop plus clr_overrun in the same cycle, and required: drop_cnt=1.
- Reset mid-stream: with level=5, assert reset_ asynchronously between edges. Required: level=0, rd_valid=0, rx_ready=0 immediately. After release, rx_ready=1 on the first edge and a new push is accepted normally.
